// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: request payload, source identifiers and the
// default sizing that the request struct is built on.
package wb_pkg;

  localparam int unsigned WB_DATA_WIDTH = 8;
  localparam int unsigned WB_NUM_REG    = 6;
  localparam int unsigned WB_SEL_W      = $clog2(WB_NUM_REG);
  localparam int unsigned WB_DEPTH      = 4;
  localparam int unsigned WB_CNT_W      = 8;

  typedef struct packed {
    logic [WB_SEL_W-1:0]      select;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } source_e;

  // Saturating increment used by the drop counter.
  function automatic logic [WB_CNT_W-1:0] sat_inc(input logic [WB_CNT_W-1:0] val);
    return (&val) ? val : val + WB_CNT_W'(1);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the two write producers / reg_bank and the writeback arbiter.
// master = producer and reg_bank side, slave = arbiter side.
interface wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REG    = 6,
  parameter int unsigned DEPTH      = 4
);

  localparam int unsigned SelW = $clog2(NUM_REG);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  i_alu_valid;
  logic                  o_alu_ready;
  logic [SelW-1:0]       i_alu_select;
  logic [DATA_WIDTH-1:0] i_alu_data;

  logic                  i_lsu_valid;
  logic                  o_lsu_ready;
  logic [SelW-1:0]       i_lsu_select;
  logic [DATA_WIDTH-1:0] i_lsu_data;

  logic                  o_write_enable;
  logic [SelW-1:0]       o_write_select;
  logic [DATA_WIDTH-1:0] o_write_data;

  logic [CntW-1:0]       o_pending;
  logic                  o_drop;
  logic [7:0]            o_drop_count;

  modport master (
    output i_alu_valid, i_alu_select, i_alu_data,
    output i_lsu_valid, i_lsu_select, i_lsu_data,
    input  o_alu_ready, o_lsu_ready,
    input  o_write_enable, o_write_select, o_write_data,
    input  o_pending, o_drop, o_drop_count
  );

  modport slave (
    input  i_alu_valid, i_alu_select, i_alu_data,
    input  i_lsu_valid, i_lsu_select, i_lsu_data,
    output o_alu_ready, o_lsu_ready,
    output o_write_enable, o_write_select, o_write_data,
    output o_pending, o_drop, o_drop_count
  );

endinterface

// File: rtl/wb_arbiter_sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter type         DATA_T = logic [7:0],
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  DATA_T           data_i,
  input  logic            pop_i,
  output DATA_T           head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  DATA_T           mem_q [DEPTH];
  DATA_T           mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty;
  logic            do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    do_push  = push_i && !full;
    do_pop   = pop_i && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through the count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between ALU and load results, drops out-of-range
// destinations, and drains one buffered write per cycle into reg_bank.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned NUM_REG    = WB_NUM_REG,
  parameter int unsigned DEPTH      = WB_DEPTH
) (
  input logic          clk,
  input logic          rst,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned SelW = $clog2(NUM_REG);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [SelW:0] NumRegExt = (SelW + 1)'(NUM_REG);

  source_e         last_grant_q, last_grant_d;
  logic            drop_q, drop_d;
  logic [7:0]      drop_count_q, drop_count_d;

  logic            alu_grant, lsu_grant;
  logic            alu_ready, lsu_ready;
  logic            accept, in_range, push, pop;
  wb_req_t         acc_req, head;
  logic [CntW-1:0] count;
  logic            full, empty;

  // Round-robin: with both valid, the source not granted last wins.
  always_comb begin
    alu_grant = bus.i_alu_valid && (!bus.i_lsu_valid || (last_grant_q == SRC_LSU));
    lsu_grant = bus.i_lsu_valid && !alu_grant;
    alu_ready = !rst && !full && alu_grant;
    lsu_ready = !rst && !full && lsu_grant;
  end

  always_comb begin
    accept         = alu_ready || lsu_ready;
    acc_req.select = alu_ready ? bus.i_alu_select : bus.i_lsu_select;
    acc_req.data   = alu_ready ? bus.i_alu_data : bus.i_lsu_data;
    in_range       = ({1'b0, acc_req.select} < NumRegExt);
    push           = accept && in_range;
    drop_d         = accept && !in_range;

    last_grant_d = last_grant_q;
    if (alu_ready) begin
      last_grant_d = SRC_ALU;
    end else if (lsu_ready) begin
      last_grant_d = SRC_LSU;
    end

    drop_count_d = drop_d ? sat_inc(drop_count_q) : drop_count_q;
    // reg_bank never stalls, so the head leaves whenever there is one.
    pop = !empty && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SRC_LSU;
      drop_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  sync_fifo #(
    .DATA_T (wb_req_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (acc_req),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.o_alu_ready    = alu_ready;
  assign bus.o_lsu_ready    = lsu_ready;
  assign bus.o_write_enable = pop;
  assign bus.o_write_select = pop ? head.select : '0;
  assign bus.o_write_data   = pop ? head.data : '0;
  assign bus.o_pending      = count;
  assign bus.o_drop         = drop_q;
  assign bus.o_drop_count   = drop_count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a queue-based writeback model
// plus a behavioural reg_bank fed by the DUT write port.
module tb_wb_arbiter;

  localparam int unsigned DW    = 8;
  localparam int unsigned NREG  = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SW    = $clog2(NREG);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_WIDTH(DW), .NUM_REG(NREG), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REG    (NREG),
    .DEPTH      (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reg_bank as seen through the DUT write port
  logic [DW-1:0] bank [NREG] = '{default: '0};
  always @(posedge clk) begin
    if (bus.o_write_enable) bank[bus.o_write_select] <= bus.o_write_data;
  end

  // Reference model
  logic [SW+DW-1:0] mq[$];
  logic [DW-1:0]    m_regs [NREG];
  int               m_last;     // 0 = ALU granted last, 1 = LSU
  logic             m_drop;
  int               m_cnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic av, input logic [SW-1:0] asel, input logic [DW-1:0] adat,
                      input logic lv, input logic [SW-1:0] lsel, input logic [DW-1:0] ldat,
                      input logic r);
    logic full, ag, lg, ear, elr, ewe;
    logic [SW-1:0] esel, s;
    logic [DW-1:0] edat, d;
    @(negedge clk);
    rst              = r;
    bus.i_alu_valid  = av;
    bus.i_alu_select = asel;
    bus.i_alu_data   = adat;
    bus.i_lsu_valid  = lv;
    bus.i_lsu_select = lsel;
    bus.i_lsu_data   = ldat;
    #1;
    full = (mq.size() == DEPTH);
    ag   = av && (!lv || m_last == 1);
    lg   = lv && !ag;
    ear  = !r && !full && ag;
    elr  = !r && !full && lg;
    ewe  = !r && (mq.size() > 0);
    esel = ewe ? mq[0][SW+DW-1:DW] : '0;
    edat = ewe ? mq[0][DW-1:0] : '0;
    check_eq("alu_ready", 32'(bus.o_alu_ready), 32'(ear));
    check_eq("lsu_ready", 32'(bus.o_lsu_ready), 32'(elr));
    check_eq("write_enable", 32'(bus.o_write_enable), 32'(ewe));
    check_eq("write_select", 32'(bus.o_write_select), 32'(esel));
    check_eq("write_data", 32'(bus.o_write_data), 32'(edat));
    check_eq("pending", 32'(bus.o_pending), 32'(mq.size()));
    check_eq("drop", 32'(bus.o_drop), 32'(m_drop));
    check_eq("drop_count", 32'(bus.o_drop_count), 32'(m_cnt));
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_last = 1;
      m_drop = 1'b0;
      m_cnt  = 0;
    end else begin
      if (ewe) begin
        m_regs[int'(esel)] = edat;
        void'(mq.pop_front());
      end
      m_drop = 1'b0;
      if (ear || elr) begin
        s      = ear ? asel : lsel;
        d      = ear ? adat : ldat;
        m_last = ear ? 0 : 1;
        if (int'(s) < NREG) begin
          mq.push_back({s, d});
        end else begin
          m_drop = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.i_alu_valid  = 1'b0;
    bus.i_alu_select = '0;
    bus.i_alu_data   = '0;
    bus.i_lsu_valid  = 1'b0;
    bus.i_lsu_select = '0;
    bus.i_lsu_data   = '0;
    m_last = 1;
    m_drop = 1'b0;
    m_cnt  = 0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Single ALU write
    step(1, 3'd2, 8'hAA, 0, 0, 0, 0);
    idle(2);
    check_eq("bank2_after_single", 32'(bank[2]), 32'h00AA);

    // Contention: grants alternate starting with whoever was not last
    for (int i = 0; i < 8; i++) step(1, 3'd1, 8'hB0 + 8'(i), 1, 3'd3, 8'hC0 + 8'(i), 0);
    idle(2);

    // Back-to-back burst from both sources with random destinations
    for (int i = 0; i < 6; i++)
      step(1, 3'($urandom_range(0, 5)), 8'($urandom), 1, 3'($urandom_range(0, 5)), 8'($urandom), 0);
    idle(2);

    // Out-of-range destination
    step(1, 3'd7, 8'hCC, 0, 0, 0, 0);
    idle(1);
    check_eq("drop_count_one", 32'(bus.o_drop_count), 32'd1);
    for (int i = 0; i < 256; i++) step(1, 3'(6 + (i % 2)), 8'(i), 0, 0, 0, 0);
    idle(1);
    check_eq("drop_count_sat", 32'(bus.o_drop_count), 32'd255);

    // Same-register ordering
    step(1, 3'd4, 8'h11, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd4, 8'h22, 0);
    idle(2);
    check_eq("bank4_order", 32'(bank[4]), 32'h0022);

    // Reset while writes are buffered
    step(1, 3'd0, 8'h5A, 1, 3'd5, 8'hA5, 0);
    step(1, 3'd0, 8'h5B, 1, 3'd5, 8'hA6, 0);
    step(1, 3'd0, 8'h5C, 1, 3'd5, 8'hA7, 1);
    idle(2);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 49) == 0));
    idle(3);

    for (int i = 0; i < NREG; i++) check_eq($sformatf("bank%0d_final", i), 32'(bank[i]),
                                            32'(m_regs[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
